// File: rtl/gpio_port_bank.sv
// Bank of NPORTS x WIDTH bidirectional GPIO pins behind a small register bus.
// Each pin has a direction and output bit, an input synchroniser, and sticky edge events.
module gpio_port_bank #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned NPORTS      = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [5:0]               addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     rdata_valid,
    output logic                     irq,
    inout  wire  [NPORTS*WIDTH-1:0]  pad_io
);

    localparam logic [2:0] REG_OUT  = 3'd0;
    localparam logic [2:0] REG_DIR  = 3'd1;
    localparam logic [2:0] REG_IN   = 3'd2;
    localparam logic [2:0] REG_EVT  = 3'd3;
    localparam logic [2:0] REG_IEN  = 3'd4;
    localparam logic [2:0] REG_EDGE = 3'd5;

    localparam int unsigned    CW        = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0]  WARM_INIT = CW'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] out_q       [NPORTS];
    logic [WIDTH-1:0] out_d       [NPORTS];
    logic [WIDTH-1:0] dir_q       [NPORTS];
    logic [WIDTH-1:0] dir_d       [NPORTS];
    logic [WIDTH-1:0] evt_q       [NPORTS];
    logic [WIDTH-1:0] evt_d       [NPORTS];
    logic [WIDTH-1:0] ien_q       [NPORTS];
    logic [WIDTH-1:0] ien_d       [NPORTS];
    logic [WIDTH-1:0] edge_mode_q [NPORTS];
    logic [WIDTH-1:0] edge_mode_d [NPORTS];
    logic [WIDTH-1:0] prev_q      [NPORTS];
    logic [WIDTH-1:0] prev_d      [NPORTS];
    logic [WIDTH-1:0] sync_q      [NPORTS][SYNC_STAGES];
    logic [WIDTH-1:0] sync_d      [NPORTS][SYNC_STAGES];

    logic [CW-1:0]    warm_q, warm_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rdata_valid_q, rdata_valid_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] s_in [NPORTS];
    logic [WIDTH-1:0] ev   [NPORTS];
    logic [WIDTH-1:0] clr  [NPORTS];
    logic [NPORTS-1:0] hit;
    logic [WIDTH-1:0] rd_val;
    logic [2:0]       port_sel;
    logic [2:0]       reg_sel;
    logic             port_ok;
    logic             warmup;

    assign port_sel = addr[5:3];
    assign reg_sel  = addr[2:0];
    assign port_ok  = 32'(port_sel) < NPORTS;
    // Synchronisers come out of reset at zero; hold off events until they hold real pad data.
    assign warmup   = warm_q != '0;

    always_comb begin
        out_d         = out_q;
        dir_d         = dir_q;
        evt_d         = evt_q;
        ien_d         = ien_q;
        edge_mode_d   = edge_mode_q;
        prev_d        = prev_q;
        sync_d        = sync_q;
        warm_d        = warmup ? warm_q - 1'b1 : warm_q;
        irq_d         = 1'b0;
        rd_val        = '0;
        hit           = '0;
        for (int unsigned p = 0; p < NPORTS; p++) begin
            s_in[p] = sync_q[p][SYNC_STAGES-1];
            ev[p]   = (s_in[p] & ~prev_q[p]) | (~edge_mode_q[p] & (s_in[p] ^ prev_q[p]));
            hit[p]  = port_ok && (port_sel == 3'(p));
            clr[p]  = (wr_en && hit[p] && reg_sel == REG_EVT) ? wdata : '0;
            // New events win over a simultaneous write-1-to-clear.
            evt_d[p] = (evt_q[p] & ~clr[p]) | (warmup ? '0 : ev[p]);
            if (wr_en && hit[p]) begin
                case (reg_sel)
                    REG_OUT:  out_d[p]       = wdata;
                    REG_DIR:  dir_d[p]       = wdata;
                    REG_IEN:  ien_d[p]       = wdata;
                    REG_EDGE: edge_mode_d[p] = wdata;
                    default:  ;
                endcase
            end
            if (hit[p]) begin
                case (reg_sel)
                    REG_OUT:  rd_val = out_q[p];
                    REG_DIR:  rd_val = dir_q[p];
                    REG_IN:   rd_val = s_in[p];
                    REG_EVT:  rd_val = evt_q[p];
                    REG_IEN:  rd_val = ien_q[p];
                    REG_EDGE: rd_val = edge_mode_q[p];
                    default:  rd_val = '0;
                endcase
            end
            irq_d        = irq_d | (|(evt_q[p] & ien_q[p]));
            prev_d[p]    = s_in[p];
            sync_d[p][0] = pad_io[p*WIDTH +: WIDTH];
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_d[p][k] = sync_q[p][k-1];
            end
        end
        rdata_d       = rd_en ? rd_val : rdata_q;
        rdata_valid_d = rd_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned p = 0; p < NPORTS; p++) begin
                out_q[p]       <= '0;
                dir_q[p]       <= '0;
                evt_q[p]       <= '0;
                ien_q[p]       <= '0;
                edge_mode_q[p] <= '0;
                prev_q[p]      <= '0;
                for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                    sync_q[p][k] <= '0;
                end
            end
            warm_q        <= WARM_INIT;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            out_q         <= out_d;
            dir_q         <= dir_d;
            evt_q         <= evt_d;
            ien_q         <= ien_d;
            edge_mode_q   <= edge_mode_d;
            prev_q        <= prev_d;
            sync_q        <= sync_d;
            warm_q        <= warm_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            irq_q         <= irq_d;
        end
    end

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        for (genvar b = 0; b < WIDTH; b++) begin : g_bit
            assign pad_io[p*WIDTH + b] = dir_q[p][b] ? out_q[p][b] : 1'bz;
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_gpio_port_bank.sv
// Directed bench for gpio_port_bank: reset, drive, latency, edge modes, W1C race, addressing.
module tb_gpio_port_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [5:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        rdata_valid;
    logic        irq;
    wire  [15:0] pad_io;
    logic [15:0] tb_en;
    logic [15:0] tb_val;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 16; i++) begin : g_pad
        assign pad_io[i] = tb_en[i] ? tb_val[i] : 1'bz;
    end

    gpio_port_bank #(
        .WIDTH       (8),
        .NPORTS      (2),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .irq         (irq),
        .pad_io      (pad_io)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, input logic [7:0] exp, input string tag);
        @(negedge clk);
        rd_en = 1'b1;
        addr  = a;
        @(negedge clk);
        rd_en = 1'b0;
        check(tag, 32'(rdata), 32'(exp));
        check({tag, "_vld"}, 32'(rdata_valid), 32'd1);
    endtask

    initial begin
        rst    = 1'b1;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        addr   = '0;
        wdata  = '0;
        tb_en  = 16'hFFFF;
        tb_val = 16'hA5A5;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_vld", 32'(rdata_valid), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("pads_undriven", 32'(pad_io), 32'hA5A5);
        check("warmup_irq", 32'(irq), 32'h0);
        rd(6'h03, 8'h00, "rst_evt0");
        rd(6'h02, 8'hA5, "rst_in0");
        rd(6'h09, 8'h00, "rst_dir1");

        // Output drive on port 1 upper nibble; lower nibble stays with the bench
        tb_en[15:12] = 4'h0;
        wr(6'h08, 8'h3C);
        wr(6'h09, 8'hF0);
        check("pad_hi_drive", 32'(pad_io[15:12]), 32'h3);
        check("pad_port0", 32'(pad_io[7:0]), 32'hA5);
        repeat (3) @(negedge clk);
        rd(6'h0A, 8'h35, "in1_readback");

        // Latency with SYNC_STAGES=2
        tb_val[0] = 1'b0;
        repeat (5) @(negedge clk);
        wr(6'h03, 8'hFF);
        wr(6'h04, 8'h01);
        rd(6'h03, 8'h00, "lat_evt_clear");
        check("lat_irq_idle", 32'(irq), 32'h0);
        tb_val[0] = 1'b1;                 // before edge 0
        @(negedge clk);                   // after edge 0
        @(negedge clk);                   // after edge 1
        rd_en = 1'b1;
        addr  = 6'h03;
        @(negedge clk);                   // after edge 2: rdata = EVT before edge 2
        check("lat_evt_pre_e2", 32'(rdata), 32'h00);
        check("lat_irq_e2", 32'(irq), 32'h0);
        @(negedge clk);                   // after edge 3: rdata = EVT after edge 2
        rd_en = 1'b0;
        check("lat_evt_e2", 32'(rdata), 32'h01);
        check("lat_irq_e3", 32'(irq), 32'h1);

        // Rising-only mode
        wr(6'h05, 8'h01);
        wr(6'h03, 8'h01);
        repeat (2) @(negedge clk);
        check("rise_irq_cleared", 32'(irq), 32'h0);
        tb_val[0] = 1'b0;
        repeat (5) @(negedge clk);
        rd(6'h03, 8'h00, "rise_fall_evt");
        check("rise_fall_irq", 32'(irq), 32'h0);
        tb_val[0] = 1'b1;
        repeat (5) @(negedge clk);
        rd(6'h03, 8'h01, "rise_rise_evt");
        check("rise_rise_irq", 32'(irq), 32'h1);

        // W1C colliding with a new event
        tb_val[0] = 1'b0;
        repeat (5) @(negedge clk);
        tb_val[0] = 1'b1;                 // before edge 0
        @(negedge clk);                   // after edge 0
        @(negedge clk);                   // after edge 1
        wr_en = 1'b1;
        addr  = 6'h03;
        wdata = 8'h01;
        @(negedge clk);                   // after edge 2
        wr_en = 1'b0;
        rd(6'h03, 8'h01, "w1c_race_evt");
        wr(6'h03, 8'h01);
        check("w1c_irq_hold", 32'(irq), 32'h1);
        @(negedge clk);
        check("w1c_irq_fall", 32'(irq), 32'h0);
        rd(6'h03, 8'h00, "w1c_evt_clear");

        // Reserved register, out-of-range port, reset during a read
        wr(6'h06, 8'hFF);
        rd(6'h06, 8'h00, "reg6_zero");
        wr(6'h28, 8'hFF);
        check("oor_pad", 32'(pad_io[15:12]), 32'h3);
        rd(6'h00, 8'h00, "oor_out0");
        rd(6'h28, 8'h00, "oor_rd");
        @(negedge clk);
        check("vld_pulse", 32'(rdata_valid), 32'h0);
        rd(6'h08, 8'h3C, "out1_kept");
        @(negedge clk);
        rd_en = 1'b1;
        addr  = 6'h08;
        rst   = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        rst   = 1'b0;
        check("midrst_vld", 32'(rdata_valid), 32'h0);
        check("midrst_rdata", 32'(rdata), 32'h00);
        check("midrst_irq", 32'(irq), 32'h0);
        rd(6'h09, 8'h00, "midrst_dir1");
        rd(6'h08, 8'h00, "midrst_out1");
        rd(6'h04, 8'h00, "midrst_ien0");
        rd(6'h05, 8'h00, "midrst_edge0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_port_bank.md
# gpio_port_bank

Parametrised bank of bidirectional I/O ports with a simple register interface. Each of `NPORTS` ports has `WIDTH` pins. Each pin has:
- a direction bit and an output value,
- an input synchroniser,
- an edge detector with sticky event flags and interrupt masking.

The bank sits between a core-side register bus and the `inout` pads, replacing hand-declared per-module input/output/inout port wiring.

## Interface
Parameters:
- `WIDTH`, 8, pins per port (1..32)
- `NPORTS`, 2, number of ports (1..8)
- `SYNC_STAGES`, 2, input synchroniser depth (2..4)

Ports:
- `clk`  input  1  clock; all logic on rising edge
- `rst`  input  1  synchronous active-high reset
- `wr_en`  input  1  register write strobe
- `rd_en`  input  1  register read strobe
- `addr`  input  6  `{port[2:0], reg[2:0]}`
- `wdata`  input  `WIDTH`  write data
- `rdata`  output  `WIDTH`  registered read data
- `rdata_valid`  output  1  high one cycle after `rd_en`
- `irq`  output  1  registered interrupt, OR of all enabled events
- `pad_io`  inout  `NPORTS*WIDTH`  pads; port p occupies bits `[p*WIDTH +: WIDTH]`

## Operation
Register map per port (`reg` field):
- 0 `OUT`: rw. Pin output value.
- 1 `DIR`: rw. 1 = drive pin, 0 = high-Z.
- 2 `IN`: ro. Last synchroniser stage. Writes ignored.
- 3 `EVT`: sticky event flags. Write-1-to-clear.
- 4 `IEN`: rw. Per-bit interrupt enable.
- 5 `EDGE`: rw. Per-bit edge mode. 0 = any edge, 1 = rising only.
- 6, 7: read 0, writes ignored.

Addressing:
- Port index >= `NPORTS`: read 0, writes ignored, `rdata_valid` still pulses.

Pad drive and input path:
- Each pad bit = `DIR[b] ? OUT[b] : 1'bz`.
- `IN` always samples the pad, so a driven pin reads back its own value.

Edge detection:
- `prev` is a flop holding the previous value of the last synchroniser stage `s`.
- `ev[b]` = `s[b] != prev[b]` when `EDGE[b]`=0.
- `ev[b]` = `s[b] & ~prev[b]` when `EDGE[b]`=1.
- Per bit, per cycle: `EVT <= (EVT & ~(wr_en_to_EVT ? wdata : 0)) | (ev & ~warmup)`. A set and a clear in the same cycle leave the bit set.

Warm-up:
- A counter loads `SYNC_STAGES+1` on reset and decrements to 0.
- `warmup` = counter != 0. While high, all events are suppressed.
- This prevents spurious events from the all-zero synchroniser reset state.

Interrupt:
- `irq` = registered OR over all ports of `|(EVT & IEN)`.

Read path:
- On `rd_en`, `rdata` captures the selected register's pre-edge value.
- A simultaneous `wr_en` to the same address therefore returns the old value.
- `rdata` holds its value when `rd_en` = 0.

Reset (`rst` high at an edge) clears:
- `OUT`, `DIR` (all pads high-Z), `EVT`, `IEN`, `EDGE`,
- synchroniser flops, `prev`,
- `rdata`, `rdata_valid`, `irq`.

Reset asserted mid-operation aborts pending reads: `rdata_valid` is 0 the next cycle.

## Timing
- Write: `OUT`/`DIR` update at edge E (`wr_en` sampled); pad reflects the new value after E.
- Read: `rd_en` at edge E → `rdata` and `rdata_valid`=1 after E. `rdata_valid` is a single-cycle pulse per `rd_en`.
- Input (pad stable before edge 0):
  - `s` updates at edge `SYNC_STAGES-1`.
  - `EVT` sets at edge `SYNC_STAGES`.
  - `irq` rises at edge `SYNC_STAGES+1`.
- A pulse shorter than one clock may be missed; no requirement on it.
- `EVT` clear → `irq` falls one edge later, unless a new event sets the bit in the same cycle.
- Warm-up: events are suppressed through edge `SYNC_STAGES+1` after reset deasserts.

## Test plan
1. **Reset state:** assert `rst` 2 cycles with pads pulled to 8'hA5.
   - Pads high-Z; `rdata`=0, `irq`=0.
   - After warm-up, read `EVT` port 0 → 0.
   - Read `IN` port 0 → 8'hA5.
2. **Output drive:** write `DIR`=8'hF0, `OUT`=8'h3C to port 1.
   - Pad bits [15:12]=4'h3 after the write edge; bits [11:8] high-Z.
   - Read `IN` port 1 → upper nibble 4'h3.
3. **Latency, `SYNC_STAGES`=2:** port 0 pad bit 0 goes 0→1 before edge 0 with `IEN`=8'h01.
   - `EVT` bit 0 = 1 after edge 2.
   - `irq` = 1 after edge 3.
4. **Rising-only mode:** `EDGE`=8'h01; drive bit 0 1→0.
   - `EVT` stays 0.
   - Then 0→1 → `EVT`=8'h01.
5. **W1C race:** write `EVT`=8'h01 in the same cycle a new edge sets bit 0 → `EVT` remains 8'h01.
   - Write again with no edge → 0.
   - `irq` falls one cycle later.
6. **Out-of-range and mid-op reset (`NPORTS`=2):**
   - Write `OUT` to port 5 → no effect; read port 5 → `rdata`=0, `rdata_valid`=1.
   - Assert `rst` in the same cycle as `rd_en` → `rdata_valid`=0 next cycle; all registers cleared.
